tpo_requant: RTL and testbench
==============================

// Module: tpo_requant
// PURPOSE
//  Back-end companion of the TPO interpolator: accepts its signed 15-bit interpolated
//  samples (qualified by en), rounds and saturates them back to signed 8-bit, buffers
//  them in a small FIFO and delivers them downstream on a valid/ready interface.
//  Sits between TPO and the carrier-offset compensation / capture path; reverses TPO's 8->15 bit growth.
// PARAMETERS
//  IW     15  input sample width (TPO OUT width)
//  OW     8   output sample width
//  DEPTH  8   FIFO depth in samples, power of two, >=2
//  SH0    7   right-shift for mode 0 (linear)
//  SH1    6   right-shift for mode 1 (parabolic)
//  SH2    5   right-shift for mode 2 (cubic); mode 3 reserved, uses SH0
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous reset, active-low
//  en          in   1       din valid this cycle (same strobe that drives TPO)
//  din         in   IW      signed interpolated sample from TPO OUT
//  mode        in   2       interpolation mode, must match TPO mode; sampled with en
//  clr         in   1       synchronous clear of ovf, sat_cnt, drop_cnt (FIFO untouched)
//  dout        out  OW      signed requantised sample, FIFO head
//  dout_valid  out  1       dout holds a valid sample (FIFO not empty)
//  dout_ready  in   1       downstream accepts dout this cycle
//  ovf         out  1       sticky: a sample was dropped on FIFO full
//  sat_cnt     out  8       saturating count of clipped samples
//  drop_cnt    out  8       saturating count of dropped samples
// BEHAVIOUR
//  Reset (rst=0, async): pipeline valids 0, FIFO empty, dout=0, dout_valid=0, ovf=0,
//   sat_cnt=0, drop_cnt=0. Release synchronous to clk.
//  Stage 1 (edge after en=1): sh=SHn(mode); sum = din + (1<<(sh-1)) in IW+1 bits
//   (no wrap); r = sum >>> sh (arithmetic; round half toward +inf).
//  Stage 2: if r > 2^(OW-1)-1 -> 2^(OW-1)-1; if r < -2^(OW-1) -> -2^(OW-1);
//   clipping increments sat_cnt (holds at 255).
//  Stage 2 result written to FIFO on following edge: en -> dout_valid latency 3
//   cycles when FIFO empty; back-to-back en sustained at 1 sample/cycle.
//  Handshake: pop when dout_valid && dout_ready; dout/dout_valid registered,
//   dout stable while dout_valid && !dout_ready. dout holds last value when empty.
//  Full: write with FIFO full and no pop -> sample dropped, ovf=1, drop_cnt++ (sat 255).
//   Full with simultaneous pop -> write accepted, no drop.
//  Empty: dout_ready ignored; no underflow, pointers unchanged.
//  clr and clipping/drop same cycle: clr wins, counters read 0 next cycle.
//  mode change mid-stream: applies per sample (captured with en); no flush.
//  Reset mid-operation: all in-flight and buffered samples discarded.
//  Pointers log2(DEPTH)+1 bits; full/empty from MSB compare; wrap-around natural.
// STRUCTURE
//  Shared package tpo_pkg: IW/OW defaults, mode encodings (MODE_LIN=0, MODE_PAR=1,
//   MODE_CUB=2), per-mode shift constants, requant rounding function.
//  One sub-module: tpo_sync_fifo (DEPTH x OW, push/pop/full/empty, registered head).
//  Requant pipeline and counters stay in tpo_requant.
// TESTING
//  1 mode0, din=1000 then -1000, dout_ready=1 -> dout 8 then -8, valid 3 cycles after en.
//  2 mode2, din=16383 then -16384 -> dout 127 then -128, sat_cnt=2, ovf=0.
//  3 dout_ready=0, 10 consecutive en samples -> 8 buffered, drop_cnt=2, ovf=1; then
//    dout_ready=1 -> 8 samples out in order, dout_valid drops after 8th.
//  4 FIFO full, en and dout_ready both high for 4 cycles -> no drops, count stays 8.
//  5 mode1, din=32 -> 1 (half rounds up); din=-32 -> 0; din=-33 -> -1.
//  6 rst=0 asserted mid-burst with 5 buffered -> dout_valid=0, counters 0 immediately,
//    first en after release yields dout_valid 3 cycles later.

Source files
------------

// File: rtl/tpo_pkg.sv
// Shared definitions for the TPO requantiser: default widths, mode encodings,
// per-mode shift amounts and the round-half-up shift helper.
package tpo_pkg;

  localparam int IW_D  = 15;
  localparam int OW_D  = 8;
  localparam int SHW   = 5;
  localparam int SH0_D = 7;
  localparam int SH1_D = 6;
  localparam int SH2_D = 5;

  typedef enum logic [1:0] {
    MODE_LIN = 2'd0,
    MODE_PAR = 2'd1,
    MODE_CUB = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  // One guard bit absorbs the rounding offset so the add never wraps.
  function automatic logic signed [IW_D:0] requant_round(
    input logic signed [IW_D-1:0] x,
    input logic [SHW-1:0]         sh
  );
    logic signed [IW_D:0] rnd;
    logic signed [IW_D:0] sum;
    rnd = $signed((IW_D + 1)'(1) << (sh - 5'd1));
    sum = $signed({x[IW_D-1], x}) + rnd;
    return sum >>> sh;
  endfunction

endpackage

// File: rtl/tpo_sync_fifo.sv
// Small synchronous FIFO whose head is held in an output register; a write into an
// empty FIFO (or into the slot that is about to become head) is bypassed straight to it.
module tpo_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  rd_q, wr_q;
  logic [AW:0]  rd_d, wr_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         pop, push_ok;

  assign full_o  = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign pop     = valid_q && ready_i;
  assign push_ok = push_i && (!full_o || pop);

  always_comb begin
    rd_d    = rd_q + {{AW{1'b0}}, pop};
    wr_d    = wr_q + {{AW{1'b0}}, push_ok};
    valid_d = (rd_d != wr_d);
    data_d  = data_q;
    if (valid_d) begin
      if (rd_d == wr_q) data_d = data_i;
      else              data_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/tpo_requant.sv
// Rounds and saturates TPO's 15-bit interpolated samples back to 8 bits and
// delivers them through a small valid/ready FIFO with clip/drop statistics.
module tpo_requant
  import tpo_pkg::*;
#(
  parameter int IW    = IW_D,
  parameter int OW    = OW_D,
  parameter int DEPTH = 8,
  parameter int SH0   = SH0_D,
  parameter int SH1   = SH1_D,
  parameter int SH2   = SH2_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [IW-1:0] din_i,
  input  logic [1:0]    mode_i,
  input  logic          clr_i,
  output logic [OW-1:0] dout_o,
  output logic          dout_valid_o,
  input  logic          dout_ready_i,
  output logic          ovf_o,
  output logic [7:0]    sat_cnt_o,
  output logic [7:0]    drop_cnt_o
);

  localparam logic signed [IW:0] R_MAX = (IW + 1)'(2 ** (OW - 1) - 1);
  localparam logic signed [IW:0] R_MIN = ~R_MAX;

  logic [SHW-1:0]      sh;
  logic                s1_valid_q;
  logic signed [IW:0]  s1_r_q;
  logic                s2_valid_q;
  logic [OW-1:0]       s2_data_q;
  logic [OW-1:0]       clip_data;
  logic                clip_hi, clip_lo, sat_hit;
  logic                fifo_full, pop, drop;
  logic                ovf_q;
  logic [7:0]          sat_cnt_q, drop_cnt_q;

  // Reserved mode 3 falls back to the linear shift.
  always_comb begin
    case (mode_e'(mode_i))
      MODE_PAR: sh = SHW'(SH1);
      MODE_CUB: sh = SHW'(SH2);
      default:  sh = SHW'(SH0);
    endcase
  end

  always_comb begin
    clip_hi = (s1_r_q > R_MAX);
    clip_lo = (s1_r_q < R_MIN);
    if (clip_hi)      clip_data = R_MAX[OW-1:0];
    else if (clip_lo) clip_data = R_MIN[OW-1:0];
    else              clip_data = s1_r_q[OW-1:0];
    sat_hit = s1_valid_q && (clip_hi || clip_lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= en_i;
      if (en_i) s1_r_q <= requant_round(din_i, sh);
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_data_q <= clip_data;
    end
  end

  tpo_sync_fifo #(
    .W     (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s2_valid_q),
    .data_i  (s2_data_q),
    .ready_i (dout_ready_i),
    .data_o  (dout_o),
    .valid_o (dout_valid_o),
    .full_o  (fifo_full)
  );

  assign pop  = dout_valid_o && dout_ready_i;
  assign drop = s2_valid_q && fifo_full && !pop;

  // clr takes priority over a same-cycle clip or drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (clr_i) begin
      ovf_q      <= 1'b0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (sat_hit && sat_cnt_q != 8'hFF)  sat_cnt_q  <= sat_cnt_q + 8'd1;
      if (drop && drop_cnt_q != 8'hFF)    drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign ovf_o      = ovf_q;
  assign sat_cnt_o  = sat_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_tpo_requant.sv
// Directed scoreboard bench for tpo_requant: expected samples are queued at issue
// time and a negedge monitor pops and compares every accepted output.
module tb_tpo_requant;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [14:0] din = '0;
  logic [1:0]  mode = '0;
  logic        clr = 1'b0;
  logic        dout_ready = 1'b1;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        ovf;
  logic [7:0]  sat_cnt;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  tpo_requant dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .din_i        (din),
    .mode_i       (mode),
    .clr_i        (clr),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .ovf_o        (ovf),
    .sat_cnt_o    (sat_cnt),
    .drop_cnt_o   (drop_cnt)
  );

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0d required=no_sample", $signed(dout));
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL pop_data actual=%0d required=%0d", $signed(dout), $signed(e));
        end else begin
          $display("pop dout=%0d", $signed(dout));
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send(input logic [1:0] m, input int d, input bit keep, input int e);
    @(posedge clk); #1;
    en   = 1'b1;
    mode = m;
    din  = 15'(d);
    if (keep) exp_q.push_back(8'(e));
    $display("send mode=%0d din=%0d expect=%0d kept=%0d", m, d, e, keep);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      en = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || dout_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_valid_after_drain"}, int'(dout_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_sat", int'(sat_cnt), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: linear rounding and 3-cycle latency
    send(2'd0, 1000, 1'b1, 8);
    idle(1);
    chk("t1_lat1", int'(dout_valid), 0);
    @(posedge clk); #1;
    chk("t1_lat2", int'(dout_valid), 0);
    @(posedge clk); #1;
    chk("t1_lat3", int'(dout_valid), 1);
    send(2'd0, -1000, 1'b1, -8);
    idle(1);
    drain("t1");

    // 2: cubic saturation both ways
    send(2'd2, 16383, 1'b1, 127);
    send(2'd2, -16384, 1'b1, -128);
    idle(1);
    drain("t2");
    chk("t2_sat_cnt", int'(sat_cnt), 2);
    chk("t2_ovf", int'(ovf), 0);

    // 5: parabolic half-up rounding, then a mode switch mid-stream
    send(2'd1, 32, 1'b1, 1);
    send(2'd1, -32, 1'b1, 0);
    send(2'd1, -33, 1'b1, -1);
    send(2'd0, 1000, 1'b1, 8);
    idle(1);
    drain("t5");
    chk("t5_sat_cnt", int'(sat_cnt), 2);

    // 3: overflow with downstream stalled
    dout_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(2'd0, i * 128, (i <= 8), i);
    idle(4);
    chk("t3_drop_cnt", int'(drop_cnt), 2);
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_valid", int'(dout_valid), 1);
    chk("t3_head", int'(dout), 1);
    dout_ready = 1'b1;
    drain("t3");
    chk("t3_hold_last", int'(dout), 8);

    // clr resets statistics
    @(posedge clk); #1;
    clr = 1'b1;
    dout_ready = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_drop", int'(drop_cnt), 0);
    chk("clr_sat", int'(sat_cnt), 0);

    // 4: full FIFO with simultaneous write and pop
    for (int i = 0; i < 8; i++) send(2'd0, (20 + i) * 128, 1'b1, 20 + i);
    idle(4);
    chk("t4_full_valid", int'(dout_valid), 1);
    for (int i = 0; i < 4; i++) begin
      send(2'd0, (28 + i) * 128, 1'b1, 28 + i);
      if (i == 2) dout_ready = 1'b1;
    end
    idle(3);
    dout_ready = 1'b0;
    chk("t4_drop_cnt", int'(drop_cnt), 0);
    chk("t4_ovf", int'(ovf), 0);
    chk("t4_head", int'(dout), 24);
    dout_ready = 1'b1;
    drain("t4");

    // 6: asynchronous reset mid-burst
    dout_ready = 1'b0;
    send(2'd2, 16383, 1'b0, 127);
    for (int i = 1; i <= 4; i++) send(2'd0, i * 128, 1'b0, i);
    idle(4);
    chk("t6_pre_valid", int'(dout_valid), 1);
    chk("t6_pre_sat", int'(sat_cnt), 1);
    send(2'd0, 640, 1'b0, 5);
    send(2'd0, 768, 1'b0, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(dout_valid), 0);
    chk("t6_rst_sat", int'(sat_cnt), 0);
    chk("t6_rst_drop", int'(drop_cnt), 0);
    chk("t6_rst_ovf", int'(ovf), 0);
    chk("t6_rst_dout", int'(dout), 0);
    en = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2'd1, -33, 1'b1, -1);
    idle(1);
    chk("t6_lat1", int'(dout_valid), 0);
    @(posedge clk); #1;
    chk("t6_lat2", int'(dout_valid), 0);
    @(posedge clk); #1;
    chk("t6_lat3", int'(dout_valid), 1);
    idle(1);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
